// File: rtl/audio_codec_controller.sv
// I2S-master audio codec controller: 1024-clock left-justified frames, 32 bits per channel.
// Optional ADC capture path is built only when AUDIO_CODEC_ADC_EN is defined.
module audio_codec_controller (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        read_audio_in,
    input  logic        write_audio_out,
    input  logic [31:0] left_channel_audio_out,
    input  logic [31:0] right_channel_audio_out,
    output logic [31:0] left_channel_audio_in,
    output logic [31:0] right_channel_audio_in,
    output logic        audio_in_available,
    output logic        audio_out_allowed,
    input  logic        AUD_ADCDAT,
    inout  wire         AUD_BCLK,
    inout  wire         AUD_ADCLRCK,
    inout  wire         AUD_DACLRCK,
    output logic        AUD_XCK,
    output logic        AUD_DACDAT
);

    logic [9:0]  cnt_q, cnt_d;
    logic [63:0] dacShift_q, dacShift_d;
    logic [63:0] hold_q, hold_d;
    logic        outAllowed_q, outAllowed_d;
    logic        frameEnd;
    logic        bitEnd;

    assign frameEnd = (cnt_q == 10'd1023);
    assign bitEnd   = (cnt_q[3:0] == 4'hF);

    // All codec clocks are straight taps of the frame counter, so reset forces them low.
    assign AUD_XCK     = cnt_q[1];
    assign AUD_BCLK    = cnt_q[3];
    assign AUD_ADCLRCK = cnt_q[9];
    assign AUD_DACLRCK = cnt_q[9];
    assign AUD_DACDAT  = dacShift_q[63];
    assign audio_out_allowed = outAllowed_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            dacShift_q   <= '0;
            hold_q       <= '0;
            outAllowed_q <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            dacShift_q   <= dacShift_d;
            hold_q       <= hold_d;
            outAllowed_q <= outAllowed_d;
        end
    end

    // Shifting on the last clock of each bit makes the new MSB appear as BCLK falls.
    always_comb begin
        cnt_d        = cnt_q + 10'd1;
        dacShift_d   = dacShift_q;
        hold_d       = hold_q;
        outAllowed_d = outAllowed_q;
        if (frameEnd) begin
            dacShift_d = outAllowed_q ? 64'd0 : hold_q;
        end else if (bitEnd) begin
            dacShift_d = {dacShift_q[62:0], 1'b0};
        end
        if (write_audio_out && outAllowed_q) begin
            hold_d       = {left_channel_audio_out, right_channel_audio_out};
            outAllowed_d = 1'b0;
        end else if (frameEnd) begin
            outAllowed_d = 1'b1;
        end
    end

`ifdef AUDIO_CODEC_ADC_EN
    logic [63:0] adcShift_q, adcShift_d;
    logic [63:0] inFrame_q, inFrame_d;
    logic        inAvail_q, inAvail_d;
    logic        sampleNow;

    assign sampleNow = (cnt_q[3:0] == 4'd8);
    assign left_channel_audio_in  = inFrame_q[63:32];
    assign right_channel_audio_in = inFrame_q[31:0];
    assign audio_in_available     = inAvail_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            adcShift_q <= '0;
            inFrame_q  <= '0;
            inAvail_q  <= 1'b0;
        end else begin
            adcShift_q <= adcShift_d;
            inFrame_q  <= inFrame_d;
            inAvail_q  <= inAvail_d;
        end
    end

    // The last sample lands at count 1016, so the shifter is complete by frame end.
    always_comb begin
        adcShift_d = adcShift_q;
        inFrame_d  = inFrame_q;
        inAvail_d  = inAvail_q;
        if (sampleNow) begin
            adcShift_d = {adcShift_q[62:0], AUD_ADCDAT};
        end
        if (frameEnd) begin
            inFrame_d = adcShift_q;
            inAvail_d = 1'b1;
        end else if (read_audio_in && inAvail_q) begin
            inAvail_d = 1'b0;
        end
    end
`else
    logic unusedAdcInputs;

    assign unusedAdcInputs        = AUD_ADCDAT ^ read_audio_in;
    assign left_channel_audio_in  = '0;
    assign right_channel_audio_in = '0;
    assign audio_in_available     = 1'b0;
`endif

endmodule

// File: tb/tb_audio_codec_controller.sv
// Self-checking bench for audio_codec_controller: frame-level reference model,
// random and directed DAC/ADC traffic, simultaneous events and mid-frame reset.
module tb_audio_codec_controller;

`ifdef AUDIO_CODEC_ADC_EN
    localparam bit AdcEn = 1'b1;
`else
    localparam bit AdcEn = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        read_audio_in;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic        audio_in_available;
    logic        audio_out_allowed;
    logic        AUD_ADCDAT;
    wire         AUD_BCLK;
    wire         AUD_ADCLRCK;
    wire         AUD_DACLRCK;
    logic        AUD_XCK;
    logic        AUD_DACDAT;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: counter position, frame on the wire, holding slot, capture state.
    int          mCnt;
    bit          mAllowed;
    logic [63:0] mHold;
    logic [63:0] mTx;
    bit          mAvail;
    logic [63:0] mIn;
    logic [63:0] curAdc;
    logic [63:0] nextAdc;

    audio_codec_controller dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .read_audio_in          (read_audio_in),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .audio_in_available     (audio_in_available),
        .audio_out_allowed      (audio_out_allowed),
        .AUD_ADCDAT             (AUD_ADCDAT),
        .AUD_BCLK               (AUD_BCLK),
        .AUD_ADCLRCK            (AUD_ADCLRCK),
        .AUD_DACLRCK            (AUD_DACLRCK),
        .AUD_XCK                (AUD_XCK),
        .AUD_DACDAT             (AUD_DACDAT)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h (cnt %0d)", tag, obs, exp, mCnt);
        end
    endtask

    function automatic logic [63:0] randFrame();
        return {$urandom, $urandom};
    endfunction

    task automatic modelReset();
        mCnt     = 0;
        mAllowed = 1'b1;
        mHold    = '0;
        mTx      = '0;
        mAvail   = 1'b0;
        mIn      = '0;
        curAdc   = randFrame();
        nextAdc  = randFrame();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_xck"}, AUD_XCK, 0);
        checkOutput({tag, "_bclk"}, AUD_BCLK, 0);
        checkOutput({tag, "_adclrck"}, AUD_ADCLRCK, 0);
        checkOutput({tag, "_daclrck"}, AUD_DACLRCK, 0);
        checkOutput({tag, "_dacdat"}, AUD_DACDAT, 0);
        checkOutput({tag, "_inL"}, left_channel_audio_in, 0);
        checkOutput({tag, "_inR"}, right_channel_audio_in, 0);
        checkOutput({tag, "_avail"}, audio_in_available, 0);
        checkOutput({tag, "_allowed"}, audio_out_allowed, 1);
    endtask

    // Every cycle: clock phases from the frame position, flags, captured data, and the
    // DAC bit at mid-slot (slot = position/16, MSB of {L,R} first).
    task automatic checkCycle();
        checkOutput("xck", AUD_XCK, (mCnt % 4) >= 2);
        checkOutput("bclk", AUD_BCLK, (mCnt % 16) >= 8);
        checkOutput("adclrck", AUD_ADCLRCK, mCnt >= 512);
        checkOutput("daclrck", AUD_DACLRCK, mCnt >= 512);
        checkOutput("allowed", audio_out_allowed, mAllowed);
        checkOutput("avail", audio_in_available, mAvail);
        checkOutput("inL", left_channel_audio_in, mIn[63:32]);
        checkOutput("inR", right_channel_audio_in, mIn[31:0]);
        if (mCnt % 16 == 8)
            checkOutput("dacdat", AUD_DACDAT, mTx[63 - mCnt / 16]);
    endtask

    // Advance one clock: apply the model's view of the coming edge, then sample at negedge.
    task automatic applyStimulus();
        if (mCnt == 1023)
            mTx = mAllowed ? 64'd0 : mHold;
        if (write_audio_out && mAllowed) begin
            mHold    = {left_channel_audio_out, right_channel_audio_out};
            mAllowed = 1'b0;
        end else if (mCnt == 1023) begin
            mAllowed = 1'b1;
        end
        if (AdcEn && mCnt == 1023) begin
            mIn    = curAdc;
            mAvail = 1'b1;
        end else if (read_audio_in && mAvail) begin
            mAvail = 1'b0;
        end
        mCnt = (mCnt + 1) % 1024;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        if (mCnt == 0) begin
            curAdc  = nextAdc;
            nextAdc = randFrame();
        end
        AUD_ADCDAT = curAdc[63 - mCnt / 16];
        checkCycle();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic runUntil(input int target);
        for (int i = 0; i < 1024 && mCnt != target; i++) applyStimulus();
    endtask

    task automatic pulseWrite(input logic [31:0] l, input logic [31:0] r);
        left_channel_audio_out  = l;
        right_channel_audio_out = r;
        write_audio_out = 1'b1;
        applyStimulus();
        write_audio_out = 1'b0;
    endtask

    task automatic releaseReset();
        reset = 1'b0;
        modelReset();
        AUD_ADCDAT = curAdc[63];
        checkCycle();
    endtask

    initial begin
        reset = 1'b1;
        read_audio_in = 1'b0;
        write_audio_out = 1'b0;
        left_channel_audio_out = '0;
        right_channel_audio_out = '0;
        AUD_ADCDAT = 1'b0;
        modelReset();
        repeat (3) @(negedge CLOCK_50);
        checkReset("por");

        // Clocking over two full frames, with random ADC traffic captured along the way.
        releaseReset();
        runCycles(2048);

        // DAC transmit of a corner pattern; a write while the slot is full must be ignored.
        runUntil(200);
        pulseWrite(32'h80000001, 32'h00000000);
        checkOutput("allowedFell", audio_out_allowed, 0);
        runUntil(400);
        pulseWrite(32'hFFFFFFFF, 32'hFFFFFFFF);
        nextAdc = 64'hA5A5A5A5_0000FFFF;
        runUntil(1023);
        applyStimulus();
        checkOutput("txLoaded", mTx, 64'h80000001_00000000);
        runUntil(1023);
        applyStimulus();
        checkOutput("capL", left_channel_audio_in, AdcEn ? 32'hA5A5A5A5 : 32'h0);
        checkOutput("capR", right_channel_audio_in, AdcEn ? 32'h0000FFFF : 32'h0);
        checkOutput("capAvail", audio_in_available, AdcEn);
        read_audio_in = 1'b1;
        applyStimulus();
        read_audio_in = 1'b0;
        checkOutput("readClears", audio_in_available, 0);

        // Write and read landing exactly on the frame boundary.
        runUntil(1023);
        read_audio_in = 1'b1;
        pulseWrite($urandom, $urandom);
        read_audio_in = 1'b0;
        checkOutput("simulAllowed", audio_out_allowed, 0);
        checkOutput("simulAvail", audio_in_available, AdcEn);
        runCycles(2048);

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            left_channel_audio_out  = $urandom;
            right_channel_audio_out = $urandom;
            write_audio_out = ($urandom_range(0, 299) == 0);
            read_audio_in   = ($urandom_range(0, 199) == 0);
            applyStimulus();
        end
        write_audio_out = 1'b0;
        read_audio_in = 1'b0;

        // Mid-frame reset with a frame pending: nothing pending may survive.
        runUntil(1023);
        applyStimulus();
        runUntil(250);
        pulseWrite($urandom | 32'h1, $urandom);
        runUntil(300);
        reset = 1'b1;
        #1;
        checkReset("midReset");
        modelReset();
        repeat (2) @(negedge CLOCK_50);
        checkReset("heldReset");
        releaseReset();
        runCycles(511);
        checkOutput("lrckBeforeRise", AUD_DACLRCK, 0);
        applyStimulus();
        checkOutput("lrckRise", AUD_DACLRCK, 1);
        runCycles(2100);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/audio_codec_controller.md
AUDIO_CODEC_CONTROLLER -- requirements
Module: audio_codec_controller

Interface
REQ-001 SHALL have port CLOCK_50, input, 1 bit: the single system clock, 50 MHz; every register is clocked on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port read_audio_in, input, 1 bit: consume the buffered input frame.
REQ-004 SHALL have port write_audio_out, input, 1 bit: load an output frame.
REQ-005 SHALL have ports left_channel_audio_out and right_channel_audio_out, input, 32 bits each: the output samples.
REQ-006 SHALL have ports left_channel_audio_in and right_channel_audio_in, output, 32 bits each: the captured samples.
REQ-007 SHALL have port audio_in_available, output, 1 bit: an unread input frame is held.
REQ-008 SHALL have port audio_out_allowed, output, 1 bit: the output holding register is empty.
REQ-009 SHALL have port AUD_ADCDAT, input, 1 bit: codec ADC serial data.
REQ-010 SHALL have ports AUD_BCLK, AUD_ADCLRCK and AUD_DACLRCK, inout, 1 bit each, always driven by this block (controller is I2S master).
REQ-011 SHALL have ports AUD_XCK and AUD_DACDAT, output, 1 bit each: codec master clock and DAC serial data.

Function
REQ-012 SHALL run a free-running 10-bit counter cnt, incremented every clock and wrapping 1023->0.
REQ-013 SHALL drive AUD_XCK = cnt[1] (12.5 MHz) and AUD_BCLK = cnt[3] (3.125 MHz, 16 clocks per bit).
REQ-014 SHALL drive AUD_ADCLRCK = AUD_DACLRCK = cnt[9], giving a 1024-clock frame of about 48.8 kHz; low = left half, high = right half.
REQ-015 SHALL use left-justified format, 32 bits per channel, MSB first; bit slot s = cnt[8:4] carries bit 31-s.
REQ-016 SHALL update AUD_DACDAT on BCLK falling edges (cnt[3:0]==0) and sample AUD_ADCDAT at BCLK rising edges (cnt[3:0]==8).
REQ-017 SHALL, when cnt==1023, transfer the output holding register (zeros if empty) into the 64-bit DAC shift register and set audio_out_allowed=1.
REQ-018 SHALL, in the clock where write_audio_out=1 and audio_out_allowed=1, latch both output samples and clear audio_out_allowed on the next edge; writes while audio_out_allowed=0 SHALL be ignored.
REQ-019 SHALL give write priority over transfer when both occur in the same cycle: the old contents are shifted out, the new data is held, and audio_out_allowed=0.
REQ-020 SHALL, when cnt==1023, copy the completed 64-bit ADC capture into left_channel_audio_in/right_channel_audio_in and set audio_in_available=1.
REQ-021 SHALL, when read_audio_in=1 and audio_in_available=1, clear audio_in_available on the next edge; the data outputs SHALL stay unchanged until the next capture.
REQ-022 SHALL overwrite an unread frame when a new capture completes; audio_in_available stays 1 and the overwrite is silent.
REQ-023 SHALL give capture priority over read when both occur in the same cycle: audio_in_available=1 with the new data.
REQ-024 SHALL make the first DAC bit of a frame written at cycle t appear on AUD_DACDAT within 1025 clocks of t.

Reset
REQ-025 SHALL, while reset=1, force the following: cnt=0; AUD_XCK, AUD_BCLK, both LRCKs and AUD_DACDAT = 0; shift and holding registers = 0; both channel_in outputs = 0; audio_in_available=0; audio_out_allowed=1.
REQ-026 SHALL restart framing from cnt=0 on the first clock after reset deasserts.
REQ-027 SHALL discard any frame in progress when reset asserts mid-frame, with no partial data reaching the outputs.

Configuration
REQ-028 SHALL, when AUDIO_CODEC_ADC_EN is defined, include the ADC capture path of REQ-016 and REQ-020 to REQ-023.
REQ-029 SHALL, when AUDIO_CODEC_ADC_EN is undefined, omit the capture logic: audio_in_available=0, channel_in outputs=0, AUD_ADCDAT ignored, and DAC and clock behaviour unchanged.

Verification
REQ-030 SHALL cover clocking: after reset, over 2048 clocks -> AUD_XCK period 4, AUD_BCLK period 16, LRCK period 1024 and low for the first 512 clocks.
REQ-031 SHALL cover DAC transmit: write L=32'h80000001, R=32'h00000000 -> audio_out_allowed falls; the next frame shows DACDAT bit 1 in slot 0, 0s in slots 1-30, bit 1 in slot 31, and 0s for the whole right half.
REQ-032 SHALL cover ADC capture: drive ADCDAT with the pattern L=32'hA5A5A5A5, R=32'h0000FFFF -> at cnt==1023 audio_in_available=1 with exactly those values; read_audio_in=1 clears the flag.
REQ-033 SHALL cover simultaneous events: write_audio_out=1 exactly when cnt==1023 -> audio_out_allowed=0 and the new data is sent in the following frame; read_audio_in=1 at capture -> audio_in_available remains 1.
REQ-034 SHALL cover reset mid-frame: assert reset at cnt=300 -> all outputs equal the REQ-025 values immediately; after release the first LRCK rise occurs 512 clocks later.
REQ-035 SHALL cover the build without AUDIO_CODEC_ADC_EN: audio_in_available stays 0 while the DAC test of REQ-031 still passes.
